// File: rtl/sram_responder_if.sv
// sram_responder_if: active-low SRAM/Flash control-signal bus between an
// initiator (master) and the memory-side responder (slave).
//   CE/OE/WE/WP : active-low chip enable, output enable, write enable, write protect
//   address     : byte address, halfword aligned
//   wdata/rdata : 16-bit write / read data
//   ready/error : completion handshake, error valid while ready is high
interface sram_responder_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 16;

  logic          CE;
  logic          OE;
  logic          WE;
  logic          WP;
  logic [AW-1:0] address;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ready;
  logic          error;

  modport master (
    output CE, OE, WE, WP, address, wdata,
    input  rdata, ready, error
  );

  modport slave (
    input  CE, OE, WE, WP, address, wdata,
    output rdata, ready, error
  );
endinterface

// File: rtl/sram_responder.sv
// sram_responder: memory-side responder for the SRAM/Flash control bus.
// Samples a request in IDLE, inserts WAIT_STATES wait cycles, performs the
// read or write on an internal 16-bit word array, then holds ready/error in
// DONE until CE returns high.
//   clk    : clock, rising edge
//   nRESET : asynchronous active-low reset
//   bus    : sram_responder_if slave modport (strobes, address, data, handshake)
module sram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int unsigned DEPTH_LOG2  = 6,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              nRESET,
  sram_responder_if.slave   bus
);
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = 4;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic                  wp_q, wp_d;
  logic                  illegal_q, illegal_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  error_q, error_d;

  logic [DW-1:0]         mem_q [DEPTH];
  logic                  mem_we_c;
  logic [DEPTH_LOG2-1:0] idx_c;
  logic                  in_win_c;
  logic                  misal_c;
  logic                  req_legal_c;
  logic                  req_illegal_c;

  // Request classification in IDLE: exactly one of OE/WE low is a legal op
  assign req_legal_c   = !bus.CE && (bus.OE != bus.WE);
  assign req_illegal_c = !bus.CE && !bus.OE && !bus.WE;

  // Decode of the latched address
  assign in_win_c = (addr_q[AW-1:DEPTH_LOG2+1] == BASE_ADDR[AW-1:DEPTH_LOG2+1]);
  assign idx_c    = addr_q[DEPTH_LOG2:1];
  assign misal_c  = addr_q[0];

  // State and datapath registers
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      wp_q      <= 1'b0;
      illegal_q <= 1'b0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      wp_q      <= wp_d;
      illegal_q <= illegal_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
    end
  end

  // Word array, intentionally not reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[idx_c] <= wdata_q;
    end
  end

  // Next-state logic; illegal ops pass through ACCESS so ready rises one
  // edge after the start regardless of the wait-state setting
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_illegal_c) begin
          state_d = S_ACCESS;
        end else if (req_legal_c) begin
          state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.CE) begin
          state_d = S_IDLE;
        end else if (cnt_q <= CW'(1)) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_d = bus.CE ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        if (bus.CE) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath / output next values and array write strobe
  always_comb begin
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    wp_d      = wp_q;
    illegal_d = illegal_q;
    rdata_d   = rdata_q;
    ready_d   = ready_q;
    error_d   = error_q;
    mem_we_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_legal_c || req_illegal_c) begin
          addr_d    = bus.address;
          wdata_d   = bus.wdata;
          write_d   = !bus.WE;
          wp_d      = bus.WP;
          illegal_d = req_illegal_c;
          cnt_d     = (req_legal_c && (WAIT_STATES != 0)) ? CW'(WAIT_STATES) : '0;
        end
      end
      S_WAIT: begin
        cnt_d = bus.CE ? '0 : (cnt_q - CW'(1));
      end
      S_ACCESS: begin
        // An abort here leaves rdata/error untouched and skips the write
        if (!bus.CE) begin
          ready_d = 1'b1;
          if (illegal_q) begin
            error_d = 1'b1;
          end else if (!in_win_c || misal_c) begin
            error_d = 1'b1;
            rdata_d = '0;
          end else if (!write_q) begin
            rdata_d = mem_q[idx_c];
            error_d = 1'b0;
          end else if (wp_q) begin
            mem_we_c = 1'b1;
            error_d  = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (bus.CE) begin
          ready_d = 1'b0;
          error_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.error = error_q;
endmodule

// File: doc/sram_responder.md
# sram_responder

Memory-side responder for the SRAM/Flash control-signal bus. It sits at the far end of the address decoder and control-signal generator. It samples the active-low CE/OE/WE/WP strobes with the address and write data, applies a programmable number of wait states, then performs a read or write on an internal word array. Completion and faults are returned to the initiator with a ready/error handshake.

## Interface
- BASE_ADDR, 32'h2000_0000, base of the responder's address window
- DEPTH_LOG2, 6, log2 of array depth in 16-bit words (default 64 words)
- WAIT_STATES, 2, wait cycles inserted before the access cycle (0..15)

- clk  input  1  single clock; all state updates on rising edge
- nRESET  input  1  asynchronous, active-low reset
- CE  input  1  chip enable, active-low; low = transaction in progress
- OE  input  1  output enable, active-low; low with CE low = read
- WE  input  1  write enable, active-low; low with CE low = write
- WP  input  1  write protect, active-low; low = writes rejected
- address  input  32  byte address, halfword aligned
- wdata  input  16  write data, sampled at transaction start
- rdata  output  16  read data, registered
- ready  output  1  transaction complete, held until CE returns high
- error  output  1  transaction faulted, valid while ready = 1

## Operation
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE: on a rising edge with CE = 0 and exactly one of OE/WE low:
  - latch address, wdata, op (read/write) and WP
  - decode the latched address:
    - in window when address[31:DEPTH_LOG2+1] == BASE_ADDR[31:DEPTH_LOG2+1]
    - word index = address[DEPTH_LOG2:1]
    - misaligned when address[0] = 1
  - go to WAIT with counter = WAIT_STATES, or go straight to ACCESS when WAIT_STATES = 0.
- IDLE with CE = 0 and both OE and WE low: illegal op; go to DONE with error = 1, no array access.
- IDLE with CE = 0 and both OE and WE high: stay in IDLE.
- WAIT: decrement the counter each cycle; when counter == 1, go to ACCESS on the next edge.
- ACCESS, on the edge into DONE:
  - out of window or misaligned: error = 1, rdata = 0, no access
  - read: rdata ← array[index], error = 0
  - write with latched WP = 1: array[index] ← latched wdata, error = 0
  - write with latched WP = 0: error = 1, array unchanged
- DONE: ready = 1 and rdata/error held stable. When CE = 1, go to IDLE; ready and error clear on that edge, rdata holds its last value.
- Abort: CE = 1 sampled in WAIT or ACCESS → IDLE next edge. No array write, ready never asserts, rdata and error unchanged.
- Changes to OE/WE/address/wdata after transaction start are ignored until IDLE is re-entered.
- The array is not reset. The bench must write before it reads.

## Timing
- Reset values: rdata = 16'h0000, ready = 0, error = 0, state = IDLE, wait counter = 0.
- Reset takes effect immediately and asynchronously, including mid-transaction; an in-flight write is discarded.
- Let E0 be the edge that samples the start in IDLE. ready rises after edge E0+WAIT_STATES+1:
  - default WAIT_STATES = 2: ready rises after E0+3
  - WAIT_STATES = 0: ready rises after E0+1
- An illegal op gives ready = 1 after E0+1.
- Array write commits at the ACCESS→DONE edge. Read data is valid in the same cycle ready rises.
- A new transaction can start no earlier than one cycle after CE high is sampled in DONE; back-to-back requests need a one-cycle CE-high gap.
- ready is level-held; the initiator must keep CE low until it sees ready, or the transaction is aborted.

## Test plan
All scenarios use the default parameters.
- Reset: hold nRESET = 0 with random CE/OE/WE → rdata = 0, ready = 0, error = 0. Assert nRESET in the WAIT state → outputs go to 0 without a clock edge.
- Write then read: write 16'hA5C3 to 32'h2000_0010 with WP = 1 → ready after E0+3, error = 0. Then read the same address → rdata = 16'hA5C3 with ready after E0+3.
- Write protect: write 16'h1234 to 32'h2000_0010 with WP = 0 → ready = 1, error = 1. Read back → 16'hA5C3.
- Decode faults:
  - read 32'h3000_0000 → error = 1, rdata = 0
  - read 32'h2000_0011 → error = 1
  - CE = 0 with OE = WE = 0 → ready after E0+1, error = 1
- Abort: start a write of 16'hFFFF to 32'h2000_0010 and raise CE at E0+1 → ready stays 0, state returns to IDLE. Read back → 16'hA5C3.
- Handshake and wrap:
  - hold CE low in DONE for 5 cycles → ready stays 1, rdata stable
  - raise CE → ready = 0 next edge
  - write/read word index 63 at 32'h2000_007E → correct data
  - read 32'h2000_0080 → error = 1
